// File: rtl/shiftreg_ring.sv
// shiftreg_ring: ordered list of WIDTH-bit entries with a run-time active
// length, head push with optional growth, and a non-destructive scan that
// streams the active entries tail first and leaves the contents unchanged.
//
// Optional build macro: SHIFTREG_RING_CLEAR_EN adds a synchronous `clear`
// input that empties the contents, restores INIT_LEN and aborts any scan.
//
// Handshake: a push is taken on a rising edge when push=1 and push_ready=1
// (push_ready is simply !scan_busy). scan_start is taken only while idle and
// beats a simultaneous push. The scan stream has no back-pressure: every
// cycle with scan_valid=1 carries one entry, and scan_done pulses once after
// the last one.
module shiftreg_ring #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 234,
  parameter int INIT_LEN = 3,
  parameter int LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFTREG_RING_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             push,
  input  logic             grow,
  input  logic [WIDTH-1:0] in_data,
  output logic             push_ready,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail,
  output logic [LEN_W-1:0] len,
  output logic             full,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_valid,
  output logic [WIDTH-1:0] scan_data,
  output logic [LEN_W-1:0] scan_idx,
  output logic             scan_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] INIT_LEN_L = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             clear_w;
  logic             do_push;
  logic             do_rot;
  logic [LEN_W-1:0] tail_idx;

`ifdef SHIFTREG_RING_CLEAR_EN
  assign clear_w = clear;
`else
  assign clear_w = 1'b0;
`endif

  // Physical index of the last active entry; clamped so len == 0 never
  // produces an out-of-range read.
  assign tail_idx = (len_q == '0) ? '0 : (len_q - 1'b1);

  // Scan FSM next state, length and scan counter; clear overrides everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    do_push = 1'b0;
    do_rot  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          // The counter tracks how many entries remain to be streamed.
          cnt_d   = len_q;
          state_d = (len_q == '0) ? ST_DONE : ST_SCAN;
        end else if (push) begin
          do_push = 1'b1;
          if (grow && (len_q != DEPTH_L)) begin
            len_d = len_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        do_rot = 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clear_w) begin
      state_d = ST_IDLE;
      len_d   = INIT_LEN_L;
      cnt_d   = '0;
      do_push = 1'b0;
      do_rot  = 1'b0;
    end
  end

  // Entry array next value: clear, full-depth shift on push, or rotation of
  // only the active range during a scan (inactive entries hold).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clear_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (do_push) begin
      mem_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end else if (do_rot) begin
      // After len rotations every active entry is back in its own slot.
      mem_d[0] = mem_q[tail_idx];
      for (int i = 1; i < DEPTH; i++) begin
        if (LEN_W'(i) < len_q) begin
          mem_d[i] = mem_q[i-1];
        end
      end
    end
  end

  // State, length and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= INIT_LEN_L;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage; every entry resets to zero so unused slots are defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs decode directly from registers, so an asynchronous reset shows
  // reset values on every output immediately.
  always_comb begin
    head       = mem_q[0];
    tail       = (len_q == '0) ? '0 : mem_q[tail_idx];
    len        = len_q;
    full       = (len_q == DEPTH_L);
    scan_busy  = (state_q != ST_IDLE);
    push_ready = (state_q == ST_IDLE);
    scan_valid = (state_q == ST_SCAN);
    scan_done  = (state_q == ST_DONE);
    scan_data  = '0;
    scan_idx   = '0;
    if (state_q == ST_SCAN) begin
      // The tail slot always holds the next entry; the counter gives its
      // logical index (len-1 first, 0 last).
      scan_data = mem_q[tail_idx];
      scan_idx  = cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_shiftreg_ring.sv
// Bench for shiftreg_ring: dut0 uses the default parameters (directed
// vectors, fill/saturation, scan streams, reset mid-scan); dut1 is a small
// ring with INIT_LEN=0 (empty scan, randomized run against a queue model,
// and clear when SHIFTREG_RING_CLEAR_EN is defined).
module tb_shiftreg_ring;

  localparam int W0 = 2;
  localparam int D0 = 234;
  localparam int I0 = 3;
  localparam int L0 = $clog2(D0 + 1);
  localparam int W1 = 4;
  localparam int D1 = 8;
  localparam int I1 = 0;
  localparam int L1 = $clog2(D1 + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  // dut0 signals
  logic          push0, grow0, ss0;
  logic [W0-1:0] in0;
  logic          ready0, full0, busy0, valid0, done0;
  logic [W0-1:0] head0, tail0, sdata0;
  logic [L0-1:0] len0, sidx0;

  // dut1 signals
  logic          push1, grow1, ss1;
  logic [W1-1:0] in1;
  logic          ready1, full1, busy1, valid1, done1;
  logic [W1-1:0] head1, tail1, sdata1;
  logic [L1-1:0] len1, sidx1;

`ifdef SHIFTREG_RING_CLEAR_EN
  logic clear0, clear1;
`endif

  shiftreg_ring #(.WIDTH(W0), .DEPTH(D0), .INIT_LEN(I0)) dut0 (
    .clk(clk), .rst(rst0),
`ifdef SHIFTREG_RING_CLEAR_EN
    .clear(clear0),
`endif
    .push(push0), .grow(grow0), .in_data(in0), .push_ready(ready0),
    .head(head0), .tail(tail0), .len(len0), .full(full0),
    .scan_start(ss0), .scan_busy(busy0), .scan_valid(valid0),
    .scan_data(sdata0), .scan_idx(sidx0), .scan_done(done0)
  );

  shiftreg_ring #(.WIDTH(W1), .DEPTH(D1), .INIT_LEN(I1)) dut1 (
    .clk(clk), .rst(rst1),
`ifdef SHIFTREG_RING_CLEAR_EN
    .clear(clear1),
`endif
    .push(push1), .grow(grow1), .in_data(in1), .push_ready(ready1),
    .head(head1), .tail(tail1), .len(len1), .full(full1),
    .scan_start(ss1), .scan_busy(busy1), .scan_valid(valid1),
    .scan_data(sdata1), .scan_idx(sidx1), .scan_done(done1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference contents: index 0 is the head, all physical slots kept.
  logic [W0-1:0] m0[$];
  int            ml0;
  logic [W1-1:0] m1[$];
  int            ml1;
  int            ph1;          // 0 idle, 1 streaming, 2 done pulse
  logic [W1-1:0] exp_q[$];     // expected scan data, in stream order
  int            exp_idx_q[$]; // expected scan indices, in stream order

  task automatic m0_push(input logic [W0-1:0] d, input logic g);
    m0.push_front(d);
    void'(m0.pop_back());
    if (g && ml0 < D0) ml0++;
  endtask

  // One dut1 cycle: drive, clock, advance the model, compare everything.
  task automatic cyc1(input logic p, input logic g, input logic [W1-1:0] d, input logic s);
    push1 = p; grow1 = g; in1 = d; ss1 = s;
    step();
    push1 = 1'b0; grow1 = 1'b0; ss1 = 1'b0;
    case (ph1)
      0: begin
        if (s) begin
          if (ml1 == 0) ph1 = 2;
          else begin
            for (int k = ml1 - 1; k >= 0; k--) begin
              exp_q.push_back(m1[k]);
              exp_idx_q.push_back(k);
            end
            ph1 = 1;
          end
        end else if (p) begin
          m1.push_front(d);
          void'(m1.pop_back());
          if (g && ml1 < D1) ml1++;
        end
      end
      1: begin
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
        if (exp_q.size() == 0) ph1 = 2;
      end
      default: ph1 = 0;
    endcase
    chk("r_valid", valid1, (ph1 == 1));
    chk("r_done", done1, (ph1 == 2));
    chk("r_busy", busy1, (ph1 != 0));
    chk("r_ready", ready1, (ph1 == 0));
    chk("r_len", len1, ml1);
    chk("r_full", full1, (ml1 == D1));
    if (ph1 == 1) begin
      chk("r_sdata", sdata1, exp_q[0]);
      chk("r_sidx", sidx1, exp_idx_q[0]);
    end else begin
      chk("r_head", head1, m1[0]);
      chk("r_tail", tail1, (ml1 == 0) ? 0 : m1[ml1-1]);
    end
  endtask

  // Scan dut0 with a push held high throughout; stream must match the model.
  task automatic scan0_check(input string tag);
    ss0 = 1'b1; push0 = 1'b1; grow0 = 1'b1; in0 = 2'd0;
    step();
    ss0 = 1'b0;
    chk({tag, "_ready_low"}, ready0, 0);
    for (int k = 0; k < ml0; k++) begin
      chk({tag, "_valid"}, valid0, 1);
      chk({tag, "_data"}, sdata0, m0[ml0-1-k]);
      chk({tag, "_idx"}, sidx0, ml0 - 1 - k);
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_len_frozen"}, len0, ml0);
      step();
    end
    chk({tag, "_done"}, done0, 1);
    chk({tag, "_valid_off"}, valid0, 0);
    step();
    push0 = 1'b0; grow0 = 1'b0;
    chk({tag, "_done_pulse"}, done0, 0);
    chk({tag, "_ready_back"}, ready0, 1);
    chk({tag, "_head_kept"}, head0, m0[0]);
    chk({tag, "_tail_kept"}, tail0, m0[ml0-1]);
    chk({tag, "_len_kept"}, len0, ml0);
  endtask

  // Directed push vectors for dut0 starting from reset.
  typedef struct {
    logic          push;
    logic          grow;
    logic [W0-1:0] din;
    logic [W0-1:0] e_head;
    logic [W0-1:0] e_tail;
    int            e_len;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W0-1:0] exp_tail;
    int            wait_n;

    vt[0] = '{push: 1'b1, grow: 1'b0, din: 2'd1, e_head: 2'd1, e_tail: 2'd0, e_len: 3};
    vt[1] = '{push: 1'b1, grow: 1'b0, din: 2'd2, e_head: 2'd2, e_tail: 2'd0, e_len: 3};
    vt[2] = '{push: 1'b1, grow: 1'b0, din: 2'd3, e_head: 2'd3, e_tail: 2'd1, e_len: 3};
    vt[3] = '{push: 1'b0, grow: 1'b1, din: 2'd0, e_head: 2'd3, e_tail: 2'd1, e_len: 3};
    vt[4] = '{push: 1'b1, grow: 1'b1, din: 2'd2, e_head: 2'd2, e_tail: 2'd1, e_len: 4};

    for (int i = 0; i < D0; i++) m0.push_back('0);
    ml0 = I0;
    for (int i = 0; i < D1; i++) m1.push_back('0);
    ml1 = I1;
    ph1 = 0;

    rst0 = 1'b1; rst1 = 1'b1;
    push0 = 1'b0; grow0 = 1'b0; in0 = '0; ss0 = 1'b0;
    push1 = 1'b0; grow1 = 1'b0; in1 = '0; ss1 = 1'b0;
`ifdef SHIFTREG_RING_CLEAR_EN
    clear0 = 1'b0; clear1 = 1'b0;
`endif
    #2;
    chk("rst_len", len0, 3);
    chk("rst_head", head0, 0);
    chk("rst_tail", tail0, 0);
    chk("rst_full", full0, 0);
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst1_len", len1, 0);
    chk("rst1_tail", tail1, 0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    // Table-driven pushes
    for (int i = 0; i < 5; i++) begin
      push0 = vt[i].push; grow0 = vt[i].grow; in0 = vt[i].din;
      step();
      push0 = 1'b0; grow0 = 1'b0;
      if (vt[i].push) m0_push(vt[i].din, vt[i].grow);
      chk($sformatf("vec%0d_head", i), head0, vt[i].e_head);
      chk($sformatf("vec%0d_tail", i), tail0, vt[i].e_tail);
      chk($sformatf("vec%0d_len", i), len0, vt[i].e_len);
      chk($sformatf("vec%0d_len_model", i), len0, ml0);
    end

    // Two scans of 2,3,2,1 give identical tail-first streams 1,2,3,2
    scan0_check("scan_a");
    scan0_check("scan_b");

    // Fill to DEPTH, then one saturating push+grow
    wait_n = 0;
    while (ml0 < D0 && wait_n < D0) begin
      push0 = 1'b1; grow0 = 1'b1; in0 = W0'($urandom_range(0, 3));
      step();
      m0_push(in0, 1'b1);
      wait_n++;
    end
    push0 = 1'b0; grow0 = 1'b0;
    chk("fill_len", len0, D0);
    chk("fill_full", full0, 1);
    chk("fill_head", head0, m0[0]);
    chk("fill_tail", tail0, m0[D0-1]);
    exp_tail = m0[D0-2];
    push0 = 1'b1; grow0 = 1'b1; in0 = 2'd3;
    step();
    push0 = 1'b0; grow0 = 1'b0;
    m0_push(2'd3, 1'b1);
    chk("sat_len", len0, D0);
    chk("sat_full", full0, 1);
    chk("sat_head", head0, 3);
    chk("sat_tail", tail0, exp_tail);

    // Reset in the middle of a long scan
    ss0 = 1'b1;
    step();
    ss0 = 1'b0;
    step();
    step();
    chk("midscan_valid", valid0, 1);
    #2;
    rst0 = 1'b1;
    #1;
    chk("arst_len", len0, 3);
    chk("arst_head", head0, 0);
    chk("arst_tail", tail0, 0);
    chk("arst_full", full0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_valid", valid0, 0);
    chk("arst_done", done0, 0);
    chk("arst_sdata", sdata0, 0);
    chk("arst_sidx", sidx0, 0);
    chk("arst_ready", ready0, 1);
    @(negedge clk);
    rst0 = 1'b0;
    step();
    chk("arst_after_busy", busy0, 0);
    chk("arst_after_len", len0, 3);

    // Empty scan on dut1: done straight away, no valid cycle
    ss1 = 1'b1;
    step();
    ss1 = 1'b0;
    chk("empty_valid", valid1, 0);
    chk("empty_done", done1, 1);
    chk("empty_busy", busy1, 1);
    step();
    chk("empty_done_pulse", done1, 0);
    chk("empty_ready", ready1, 1);

    // Randomized run against the queue model
    for (int c = 0; c < 600; c++) begin
      cyc1(($urandom_range(0, 9) < 6), $urandom_range(0, 1), W1'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0));
    end
    wait_n = 0;
    while (ph1 != 0 && wait_n < 20) begin
      cyc1(1'b0, 1'b0, '0, 1'b0);
      wait_n++;
    end
    chk("drain_idle", (ph1 == 0), 1);

`ifdef SHIFTREG_RING_CLEAR_EN
    // Clear aborts a scan: no done pulse, empty contents, INIT_LEN
    cyc1(1'b1, 1'b1, 4'd5, 1'b0);
    cyc1(1'b1, 1'b1, 4'd9, 1'b0);
    cyc1(1'b0, 1'b0, '0, 1'b1);
    chk("clr_pre_valid", valid1, 1);
    clear1 = 1'b1;
    step();
    clear1 = 1'b0;
    chk("clr_done", done1, 0);
    chk("clr_busy", busy1, 0);
    chk("clr_valid", valid1, 0);
    chk("clr_len", len1, I1);
    chk("clr_head", head1, 0);
    step();
    chk("clr_no_done", done1, 0);
    chk("clr_ready", ready1, 1);
    m1.delete();
    for (int i = 0; i < D1; i++) m1.push_back('0);
    ml1 = I1; ph1 = 0;
    exp_q.delete(); exp_idx_q.delete();
    cyc1(1'b1, 1'b0, 4'd7, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shiftreg_ring.md
Name: shiftreg_ring

Overview:
- Parametrised successor to the fixed 2-bit × 234 body shift register.
- Holds an ordered list of WIDTH-bit entries, for example snake segment coordinates, with a run-time active length.
- Supports head push with optional growth.
- Supports a non-destructive recirculating scan that streams every active entry for collision checks and rendering, then leaves the contents exactly as before.

Parameters:
- WIDTH, 2: bits per entry.
- DEPTH, 234: physical entries; maximum length.
- INIT_LEN, 3: active length after reset; must satisfy 0 ≤ INIT_LEN ≤ DEPTH.
- LEN_W, $clog2(DEPTH+1): width of length and index values.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  shift `in_data` into the head (entry 0).
- grow  in  1  qualifies `push`: length increments and the tail is kept.
- in_data  in  WIDTH  new head entry.
- push_ready  out  1  high when a push is accepted; equals !scan_busy.
- head  out  WIDTH  entry 0.
- tail  out  WIDTH  entry len-1; 0 when len == 0.
- len  out  LEN_W  active length.
- full  out  1  len == DEPTH.
- scan_start  in  1  request a full scan.
- scan_busy  out  1  scan in progress.
- scan_valid  out  1  scan_data/scan_idx valid this cycle.
- scan_data  out  WIDTH  streamed entry.
- scan_idx  out  LEN_W  index of the streamed entry.
- scan_done  out  1  one-cycle pulse after the last entry.

Behaviour:
- Reset values:
  - all entries = 0, len = INIT_LEN.
  - FSM = IDLE.
  - scan_busy, scan_valid and scan_done = 0; scan_data and scan_idx = 0.
  - push_ready = 1.
- Reset mid-scan aborts immediately; the contents return to their reset values.
- Push, only in IDLE with push=1:
  - entry[i] <= entry[i-1] for 1 ≤ i < DEPTH; entry[0] <= in_data.
  - head updates the next cycle.
  - grow=1 and !full: len <= len+1. The old tail becomes entry len_old, the new tail.
  - grow=1 and full: len saturates at DEPTH; the oldest entry is dropped.
  - grow=0: len unchanged; the old tail falls out of the active range.
- grow without push has no effect.
- Entries at index ≥ len are don't-care contents, but they must be deterministic: push shifts them, scan holds them.
- Scan FSM, states IDLE, SCAN, DONE:
  - IDLE→SCAN on scan_start. scan_start wins over a simultaneous push, which is ignored; push_ready falls the cycle after scan_start.
  - The cycle counter is loaded with len.
  - scan_start in IDLE with len == 0: IDLE→DONE directly, no valid cycles.
  - scan_start while busy is ignored.
- Each SCAN cycle:
  - scan_valid = 1, scan_data = entry[len-1], scan_idx = current logical index.
  - Indices are emitted tail first: len-1, len-2, …, 0.
  - Rotate the active range: entry[0] <= entry[len-1]; entry[i] <= entry[i-1] for 1 ≤ i < len. Entries ≥ len hold.
- SCAN→DONE after exactly len valid cycles. The contents are then bit-identical to the pre-scan contents.
- DONE: scan_done = 1 for one cycle, then →IDLE; push_ready = 1 again from the IDLE cycle.
- Scan latency: scan_start at cycle t gives the first valid at t+1, the last valid at t+len, scan_done at t+len+1.
- len is frozen during a scan; push and grow are ignored.

Optional Feature:
- Macro SHIFTREG_RING_CLEAR_EN adds input `clear` (1 bit).
- When defined:
  - clear=1 synchronously sets all entries to 0, len to INIT_LEN and the FSM to IDLE.
  - clear has priority over scan_start and push, and aborts a scan with no scan_done.
- When undefined: the port is absent and the remaining behaviour is identical.

Test Plan:
- Reset with INIT_LEN=3, WIDTH=2 → len=3, head=0, tail=0, full=0, push_ready=1, scan_busy=0.
- Push with grow=0 of 1, 2, 3 → head=3, tail=1, len=3. Then push+grow of 2 → len=4, head=2, tail=1.
- Fill to len=DEPTH with push+grow → full=1. A further push+grow keeps len=DEPTH and drops the oldest entry: tail becomes the former entry DEPTH-2.
- Contents head→tail 2,3,2,1 at len=4, then scan_start → valid for 4 cycles with data 1,2,3,2 and idx 3,2,1,0. scan_done at t+5. A subsequent scan gives the identical stream. push during scan → ignored, push_ready=0.
- scan_start with len=0 (INIT_LEN=0) → scan_done at t+1, no scan_valid. Assert rst mid-scan → all outputs at reset values immediately.
- SHIFTREG_RING_CLEAR_EN: clear during scan → no scan_done, len=INIT_LEN, all entries 0 the next cycle.
